// File: rtl/board_timing_pkg.sv
// Shared board timing constants for the 25 MHz Go Board and the repeat-FSM state type.
package board_timing_pkg;

  localparam int unsigned CLK_HZ        = 25_000_000;
  localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

  localparam int unsigned DEBOUNCE_MS      = 10;
  localparam int unsigned REPEAT_DELAY_MS  = 500;
  localparam int unsigned REPEAT_PERIOD_MS = 100;

  localparam int unsigned DEBOUNCE_CYCLES      = CYCLES_PER_MS * DEBOUNCE_MS;
  localparam int unsigned REPEAT_DELAY_CYCLES  = CYCLES_PER_MS * REPEAT_DELAY_MS;
  localparam int unsigned REPEAT_PERIOD_CYCLES = CYCLES_PER_MS * REPEAT_PERIOD_MS;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DELAY,
    REPEATING
  } repeat_state_e;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus counter-based debounce; the stable level flips only after
// DEBOUNCE_LIMIT consecutive cycles of disagreement.
module debounce_filter
  import board_timing_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic flip
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT);

  logic             sync0_q, sync1_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // flip is the load strobe of the stable flop, so the parent can register edge pulses that
  // land in the same cycle as the level change.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    flip     = 1'b0;
    if (sync1_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
        flip     = 1'b1;
        stable_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync0_q  <= raw;
      sync1_q  <= sync0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/switch_event_debounce.sv
// Debounced push-button with registered press/release pulses and an auto-repeat pulse
// train while the button is held.
module switch_event_debounce
  import board_timing_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY   = REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD  = REPEAT_PERIOD_CYCLES,
  parameter bit          REPEAT_EN      = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Repeat
);

  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  logic level, flip;

  debounce_filter #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_filter (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .raw  (i_Switch),
    .level(level),
    .flip (flip)
  );

  repeat_state_e    state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    press_d   = flip & ~level;
    release_d = flip & level;
    repeat_d  = 1'b0;
    if (!REPEAT_EN || release_d) begin
      // Release wins over any repeat due in the same cycle.
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d = HOLD_DELAY;
            tmr_d   = '0;
          end
        end
        HOLD_DELAY: begin
          if (tmr_q == TMR_W'(REPEAT_DELAY - 1)) begin
            repeat_d = 1'b1;
            tmr_d    = '0;
            state_d  = REPEATING;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        REPEATING: begin
          if (tmr_q == TMR_W'(REPEAT_PERIOD - 1)) begin
            repeat_d = 1'b1;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_Switch  = level;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Repeat  = repeat_q;

endmodule

// File: tb/tb_switch_event_debounce.sv
// Randomised bench: a window-based reference model queues expected pulse events and a
// negedge monitor pops and compares them for an auto-repeat DUT and a repeat-disabled DUT.
module tb_switch_event_debounce;

  localparam int L    = 4;
  localparam int D    = 10;
  localparam int P    = 3;
  localparam int MAXC = 50000;

  localparam int KPRESS = 0;
  localparam int KREL   = 1;
  localparam int KREP   = 2;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;

  logic sw_a, pr_a, rl_a, rp_a;
  logic sw_b, pr_b, rl_b, rp_b;

  switch_event_debounce #(
    .DEBOUNCE_LIMIT(L),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P),
    .REPEAT_EN     (1'b1)
  ) dut_a (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw),
    .o_Switch (sw_a),
    .o_Press  (pr_a),
    .o_Release(rl_a),
    .o_Repeat (rp_a)
  );

  switch_event_debounce #(
    .DEBOUNCE_LIMIT(L),
    .REPEAT_DELAY  (D),
    .REPEAT_PERIOD (P),
    .REPEAT_EN     (1'b0)
  ) dut_b (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw),
    .o_Switch (sw_b),
    .o_Press  (pr_b),
    .o_Release(rl_b),
    .o_Repeat (rp_b)
  );

  always #5 clk = ~clk;

  ev_t qa[$];
  ev_t qb[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  xh[0:MAXC];

  // Reference model state
  bit  m_stable = 1'b0;
  bit  m_flip;
  bit  m_ok;
  int  m_last_flip = 0;
  int  m_anchor = -1;

  function automatic ev_t mk(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    return e;
  endfunction

  // Stable level flips at edge t when the synchronised input (raw input two edges earlier)
  // differed from it on each of the last L edges, all after the previous flip or reset.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc >= MAXC) begin
        $display("FAIL cycle budget: reached %0d cycles, required fewer than %0d", cyc, MAXC);
        $fatal(1, "cycle budget exceeded");
      end
      if (rst) begin
        xh[cyc]     = 1'b0;
        m_stable    = 1'b0;
        m_last_flip = cyc;
        m_anchor    = -1;
      end else begin
        xh[cyc] = sw;
        m_ok = (cyc - L + 1 > m_last_flip);
        if (m_ok)
          for (int i = cyc - L + 1; i <= cyc; i++)
            if (xh[i-2] == m_stable) m_ok = 1'b0;
        m_flip = m_ok;
        if (m_flip) begin
          m_stable    = ~m_stable;
          m_last_flip = cyc;
          if (m_stable) begin
            qa.push_back(mk(cyc, KPRESS));
            qb.push_back(mk(cyc, KPRESS));
            m_anchor = cyc;
          end else begin
            qa.push_back(mk(cyc, KREL));
            qb.push_back(mk(cyc, KREL));
            m_anchor = -1;
          end
        end else if (m_anchor >= 0 && cyc - m_anchor >= D && ((cyc - m_anchor - D) % P) == 0) begin
          qa.push_back(mk(cyc, KREP));
        end
      end
    end
  end

  task automatic expect_pulse(input int d, input int kind);
    ev_t e;
    bit  empty;
    total++;
    empty = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
    if (empty) begin
      bad++;
      $display("FAIL pulse dut%0d: got kind %0d at cycle %0d, required no pulse", d, kind, cyc);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else        e = qb.pop_front();
    if (e.cyc != cyc || e.kind != kind) begin
      bad++;
      $display("FAIL pulse dut%0d: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
               d, kind, cyc, e.kind, e.cyc);
    end
  endtask

  task automatic check_missed(input int d);
    ev_t e;
    bit  late;
    total++;
    late = 1'b0;
    if (d == 0 && qa.size() > 0 && qa[0].cyc < cyc) begin
      late = 1'b1;
      e = qa.pop_front();
    end else if (d == 1 && qb.size() > 0 && qb[0].cyc < cyc) begin
      late = 1'b1;
      e = qb.pop_front();
    end
    if (late) begin
      bad++;
      $display("FAIL missed dut%0d: no pulse seen, required kind %0d at cycle %0d",
               d, e.kind, e.cyc);
    end
  endtask

  task automatic check_level(input int d, input logic got);
    total++;
    if (got !== m_stable) begin
      bad++;
      $display("FAIL level dut%0d cycle %0d: got %b, required %b", d, cyc, got, m_stable);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      check_level(0, sw_a);
      check_level(1, sw_b);
      if (pr_a !== 1'b0) expect_pulse(0, KPRESS);
      if (rl_a !== 1'b0) expect_pulse(0, KREL);
      if (rp_a !== 1'b0) expect_pulse(0, KREP);
      if (pr_b !== 1'b0) expect_pulse(1, KPRESS);
      if (rl_b !== 1'b0) expect_pulse(1, KREL);
      if (rp_b !== 1'b0) expect_pulse(1, KREP);
      check_missed(0);
      check_missed(1);
    end
  end

  task automatic hold(input logic v, input int n);
    sw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int r;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Directed: glitch, clean press with repeats, release mid-repeat, re-press, reset mid-hold
    hold(1'b1, 3);
    hold(1'b0, 20);
    hold(1'b1, 30);
    hold(1'b0, 15);
    hold(1'b1, 25);
    do_reset();
    hold(1'b1, 20);
    hold(1'b0, 15);
    hold(1'b1, 60);
    hold(1'b0, 15);
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)     do_reset();
      else if (r < 5) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
      else            hold(1'($urandom_range(0, 1)), int'($urandom_range(4, 40)));
    end
    hold(1'b0, 30);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending events, required 0/0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
